j17_control_unit: RTL and testbench

- Fetch/decode sequencer directly upstream of the J17 datapath.
- Fetches 32-bit instructions over a req/ack handshake using the datapath's PC, latches them in an instruction register and decodes them.
- Drives the datapath control fields (alucode, op1, op2, imControl, regenable, ramenable, pcControl, writecode).
- Issues one dp_step strobe per instruction. The datapath commits register, RAM and PC updates only on dp_step.

---
 rtl/j17_pkg.sv | 43 ++++
 rtl/j17_decoder.sv | 94 +++++++++
 rtl/j17_control_unit.sv | 209 ++++++++++++++++++++
 tb/tb_j17_control_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/j17_pkg.sv
// Shared definitions for the J17 fetch/decode sequencer.
//   - opcode constants and the highest ALU opcode
//   - sequencer state encoding
//   - ramenable / writecode encodings
//   - instruction field bit positions
package j17_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_MEMWAIT = 3'd3,
        ST_EXECUTE = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    // Opcodes 0..OP_ALU_LAST go straight to the ALU; 16..30 are illegal.
    localparam logic [4:0] OP_ALU_LAST = 5'd11;
    localparam logic [4:0] OP_LI       = 5'd12;
    localparam logic [4:0] OP_LOAD     = 5'd13;
    localparam logic [4:0] OP_STORE    = 5'd14;
    localparam logic [4:0] OP_BRANCH   = 5'd15;
    localparam logic [4:0] OP_HALT     = 5'd31;

    localparam logic [1:0] RAM_IDLE  = 2'b00;
    localparam logic [1:0] RAM_READ  = 2'b01;
    localparam logic [1:0] RAM_WRITE = 2'b10;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_NUM2 = 2'd1;
    localparam logic [1:0] WB_RAM  = 2'd2;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 27;
    localparam int IMM_BIT = 26;
    localparam int COND_HI = 26;
    localparam int COND_LO = 24;
    localparam int OP1_HI  = 23;
    localparam int OP1_LO  = 19;
    localparam int OP2_HI  = 18;
    localparam int OP2_LO  = 14;

endpackage

// File: rtl/j17_decoder.sv
// Purely combinational instruction decoder.
// Ports:
//   ir          in  32  instruction word
//   alucode     out 5   ALU operation
//   op1, op2    out 5   register / immediate fields
//   imm         out 1   op2 is an immediate
//   reg_we      out 1   instruction writes a register (applied in EXECUTE)
//   ram_mode    out 2   RAM access kind (read for LOAD, write for STORE)
//   pc_mode     out 3   PC update mode (branch condition, 0 = PC+1)
//   wb_sel      out 2   write-back source
//   is_load     out 1   instruction needs the MEMWAIT phase
//   is_halt     out 1   HALT instruction
//   is_illegal  out 1   opcode 16..30, executed as a NOP
module j17_decoder
    import j17_pkg::*;
(
    input  logic [31:0] ir,
    output logic [4:0]  alucode,
    output logic [4:0]  op1,
    output logic [4:0]  op2,
    output logic        imm,
    output logic        reg_we,
    output logic [1:0]  ram_mode,
    output logic [2:0]  pc_mode,
    output logic [1:0]  wb_sel,
    output logic        is_load,
    output logic        is_halt,
    output logic        is_illegal
);

    logic [4:0] opcode;
    logic       unused_ir;

    assign opcode    = ir[OPC_HI:OPC_LO];
    assign unused_ir = ^ir[OP2_LO-1:0];

    always_comb begin
        alucode    = '0;
        op1        = '0;
        op2        = '0;
        imm        = 1'b0;
        reg_we     = 1'b0;
        ram_mode   = RAM_IDLE;
        pc_mode    = '0;
        wb_sel     = WB_ALU;
        is_load    = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;

        if (opcode <= OP_ALU_LAST) begin
            alucode = opcode;
            op1     = ir[OP1_HI:OP1_LO];
            op2     = ir[OP2_HI:OP2_LO];
            imm     = ir[IMM_BIT];
            reg_we  = 1'b1;
        end else begin
            case (opcode)
                OP_LI: begin
                    op1    = ir[OP1_HI:OP1_LO];
                    op2    = ir[OP2_HI:OP2_LO];
                    imm    = 1'b1;
                    wb_sel = WB_NUM2;
                    reg_we = 1'b1;
                end
                OP_LOAD: begin
                    op1      = ir[OP1_HI:OP1_LO];
                    op2      = ir[OP2_HI:OP2_LO];
                    ram_mode = RAM_READ;
                    wb_sel   = WB_RAM;
                    reg_we   = 1'b1;
                    is_load  = 1'b1;
                end
                OP_STORE: begin
                    op1      = ir[OP1_HI:OP1_LO];
                    op2      = ir[OP2_HI:OP2_LO];
                    ram_mode = RAM_WRITE;
                end
                OP_BRANCH: begin
                    op1     = ir[OP1_HI:OP1_LO];
                    op2     = ir[OP2_HI:OP2_LO];
                    pc_mode = ir[COND_HI:COND_LO];
                end
                OP_HALT: begin
                    is_halt = 1'b1;
                end
                default: begin
                    // Illegal: every field stays zero so the datapath sees a NOP.
                    is_illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/j17_control_unit.sv
// J17 fetch/decode sequencer. Fetches an instruction over req/ack, decodes it
// and presents datapath control fields, issuing one dp_step per instruction.
// Ports:
//   clock, reset         clock and asynchronous active-high reset
//   pc                   current PC from the datapath
//   imem_req/addr/ack/data  instruction fetch handshake
//   alucode, op1, op2, imControl, regenable, ramenable, pcControl, writecode
//                        datapath control fields
//   dp_step              datapath commit strobe (EXECUTE)
//   halted               core stopped on HALT
//   illegal              sticky illegal-opcode flag
//   retired              retired-instruction count
module j17_control_unit
    import j17_pkg::*;
#(
    parameter int IMEM_AW  = 10,
    parameter int MEM_WAIT = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        pc,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_data,
    output logic [4:0]         alucode,
    output logic [4:0]         op1,
    output logic [4:0]         op2,
    output logic               imControl,
    output logic               regenable,
    output logic [1:0]         ramenable,
    output logic [2:0]         pcControl,
    output logic [1:0]         writecode,
    output logic               dp_step,
    output logic               halted,
    output logic               illegal,
    output logic [31:0]        retired
);

    // MEMWAIT counts down from MEM_WAIT-1 and leaves when it reaches zero,
    // giving exactly MEM_WAIT cycles in that state.
    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

    state_t      state_reg, state_next;
    logic [31:0] ir_reg, ir_next;
    logic        ir_accept;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;
    logic [31:0] retired_reg;
    logic        illegal_reg;

    // Registered control fields, valid from DECODE through EXECUTE.
    logic [4:0]  alucode_reg, op1_reg, op2_reg;
    logic        imm_reg, reg_we_reg, ill_instr_reg;
    logic [1:0]  ram_mode_reg, wb_sel_reg;
    logic [2:0]  pc_mode_reg;

    logic [4:0]  dec_alucode, dec_op1, dec_op2;
    logic        dec_imm, dec_reg_we, dec_is_load, dec_is_halt, dec_is_illegal;
    logic [1:0]  dec_ram_mode, dec_wb_sel;
    logic [2:0]  dec_pc_mode;

    logic        unused_pc;

    assign unused_pc = ^pc;

    // The decoder looks at the value IR is about to hold, so the control
    // fields can be registered on the same edge that captures the instruction.
    assign ir_accept = (state_reg == ST_FETCH) && imem_ack;
    assign ir_next   = ir_accept ? imem_data : ir_reg;

    j17_decoder u_decoder (
        .ir         (ir_next),
        .alucode    (dec_alucode),
        .op1        (dec_op1),
        .op2        (dec_op2),
        .imm        (dec_imm),
        .reg_we     (dec_reg_we),
        .ram_mode   (dec_ram_mode),
        .pc_mode    (dec_pc_mode),
        .wb_sel     (dec_wb_sel),
        .is_load    (dec_is_load),
        .is_halt    (dec_is_halt),
        .is_illegal (dec_is_illegal)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            ir_reg       <= '0;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            ir_reg       <= ir_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        imem_req      = 1'b0;
        imem_addr     = '0;
        dp_step       = 1'b0;
        halted        = 1'b0;
        regenable     = 1'b0;
        ramenable     = RAM_IDLE;

        case (state_reg)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req  = 1'b1;
                imem_addr = pc[IMEM_AW-1:0];
                if (imem_ack) begin
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_is_halt) begin
                    state_next = ST_HALT;
                end else if (dec_is_load) begin
                    state_next    = ST_MEMWAIT;
                    wait_cnt_next = WAIT_INIT;
                end else begin
                    state_next = ST_EXECUTE;
                end
            end
            ST_MEMWAIT: begin
                ramenable = ram_mode_reg;
                if (wait_cnt_reg == 4'd0) begin
                    state_next = ST_EXECUTE;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            ST_EXECUTE: begin
                dp_step    = 1'b1;
                regenable  = reg_we_reg;
                ramenable  = ram_mode_reg;
                state_next = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Fields load on entry to DECODE and clear whenever the sequencer goes
    // back to fetching or stops, so they read zero outside an instruction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            alucode_reg   <= '0;
            op1_reg       <= '0;
            op2_reg       <= '0;
            imm_reg       <= 1'b0;
            reg_we_reg    <= 1'b0;
            ram_mode_reg  <= RAM_IDLE;
            pc_mode_reg   <= '0;
            wb_sel_reg    <= WB_ALU;
            ill_instr_reg <= 1'b0;
        end else if (state_next == ST_DECODE) begin
            alucode_reg   <= dec_alucode;
            op1_reg       <= dec_op1;
            op2_reg       <= dec_op2;
            imm_reg       <= dec_imm;
            reg_we_reg    <= dec_reg_we;
            ram_mode_reg  <= dec_ram_mode;
            pc_mode_reg   <= dec_pc_mode;
            wb_sel_reg    <= dec_wb_sel;
            ill_instr_reg <= dec_is_illegal;
        end else if (state_next == ST_FETCH || state_next == ST_HALT) begin
            alucode_reg   <= '0;
            op1_reg       <= '0;
            op2_reg       <= '0;
            imm_reg       <= 1'b0;
            reg_we_reg    <= 1'b0;
            ram_mode_reg  <= RAM_IDLE;
            pc_mode_reg   <= '0;
            wb_sel_reg    <= WB_ALU;
            ill_instr_reg <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retired_reg <= '0;
            illegal_reg <= 1'b0;
        end else if (state_reg == ST_EXECUTE) begin
            retired_reg <= retired_reg + 32'd1;
            if (ill_instr_reg) begin
                illegal_reg <= 1'b1;
            end
        end
    end

    assign alucode   = alucode_reg;
    assign op1       = op1_reg;
    assign op2       = op2_reg;
    assign imControl = imm_reg;
    assign pcControl = pc_mode_reg;
    assign writecode = wb_sel_reg;
    assign illegal   = illegal_reg;
    assign retired   = retired_reg;

endmodule

// File: tb/tb_j17_control_unit.sv
// Scoreboard bench for j17_control_unit: instructions are issued over the
// fetch handshake and their expected datapath controls queued; a monitor
// pops and compares on every dp_step.
module tb_j17_control_unit;

    localparam int AW = 10;
    localparam int MW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   pc;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [31:0]   imem_data = '0;
    logic [4:0]    alucode, op1, op2;
    logic          imControl, regenable, dp_step, halted, illegal;
    logic [1:0]    ramenable, writecode;
    logic [2:0]    pcControl;
    logic [31:0]   retired;

    logic [31:0]   pc_base = '0;
    logic [31:0]   steps = '0;
    assign pc = pc_base + steps;

    always #5 clock = ~clock;

    j17_control_unit #(.IMEM_AW(AW), .MEM_WAIT(MW)) dut (
        .clock     (clock),
        .reset     (reset),
        .pc        (pc),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .alucode   (alucode),
        .op1       (op1),
        .op2       (op2),
        .imControl (imControl),
        .regenable (regenable),
        .ramenable (ramenable),
        .pcControl (pcControl),
        .writecode (writecode),
        .dp_step   (dp_step),
        .halted    (halted),
        .illegal   (illegal),
        .retired   (retired)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [4:0]  alucode, op1, op2;
        logic        imm, regen, ill;
        logic [1:0]  wc, ramen;
        logic [2:0]  pcctl;
        bit          chk_alu, chk_ops;
        int          busy, ram_cycles;
    } exp_t;

    exp_t sb_q[$];

    // Reference model: what the spec says the datapath must see for one instruction.
    function automatic exp_t model(input logic [31:0] ins);
        exp_t e;
        int   opc;
        opc          = int'(ins[31:27]);
        e.ins        = ins;
        e.alucode    = '0;
        e.op1        = ins[23:19];
        e.op2        = ins[18:14];
        e.imm        = 1'b0;
        e.regen      = 1'b0;
        e.ill        = 1'b0;
        e.wc         = 2'd0;
        e.ramen      = 2'b00;
        e.pcctl      = 3'd0;
        e.chk_alu    = 1'b0;
        e.chk_ops    = 1'b1;
        e.busy       = 2;
        e.ram_cycles = 0;
        if (opc <= 11) begin
            e.alucode = 5'(opc); e.imm = ins[26]; e.regen = 1'b1; e.chk_alu = 1'b1;
        end else if (opc == 12) begin
            e.imm = 1'b1; e.wc = 2'd1; e.regen = 1'b1; e.chk_alu = 1'b1;
        end else if (opc == 13) begin
            e.ramen = 2'b01; e.wc = 2'd2; e.regen = 1'b1;
            e.busy = 2 + MW; e.ram_cycles = MW + 1;
        end else if (opc == 14) begin
            e.ramen = 2'b10;
        end else if (opc == 15) begin
            e.pcctl = ins[26:24];
        end else begin
            e.ill = 1'b1; e.chk_ops = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [31:0] mk(input int opc, input int c3, input int r1, input int r2);
        return {5'(opc), 3'(c3), 5'(r1), 5'(r2), 14'(c3 * 97)};
    endfunction

    function automatic logic [31:0] rand_instr(input bit allow_ill);
        logic [31:0] w;
        w = $urandom;
        if (allow_ill && $urandom_range(0, 7) == 0) w[31:27] = 5'($urandom_range(16, 30));
        else w[31:27] = 5'($urandom_range(0, 15));
        return w;
    endfunction

    // Serve one fetch: wait for the request, hold off 'delay' cycles, then ack.
    // Returns at the negedge of the DECODE cycle.
    task automatic fetch_one(input logic [31:0] ins, input int delay);
        int t;
        t = 0;
        while (!imem_req && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!imem_req) begin
            check("fetch_req_timeout", 32'(imem_req), 32'd1);
            return;
        end
        check("fetch_addr", 32'(imem_addr), 32'(pc[AW-1:0]));
        for (int d = 0; d < delay; d++) begin
            @(negedge clock);
            check("wait_req_held", {30'd0, imem_req, dp_step}, 32'b10);
            check("wait_addr_stable", 32'(imem_addr), 32'(pc[AW-1:0]));
        end
        imem_data = ins;
        imem_ack  = 1'b1;
        if (ins[31:27] != 5'd31) sb_q.push_back(model(ins));
        @(negedge clock);
        imem_ack  = 1'b0;
        imem_data = $urandom;
    endtask

    // Monitor / scoreboard.
    int   win = 0, ram_cnt = 0, txn = 0;
    int   retired_model = 0;
    bit   illegal_model = 1'b0;
    exp_t mon_e;

    always @(negedge clock) begin
        if (reset) begin
            sb_q.delete();
            retired_model = 0;
            illegal_model = 1'b0;
            win = 0;
            ram_cnt = 0;
        end else if (imem_req) begin
            win = 0;
            ram_cnt = 0;
        end else if (!halted) begin
            win++;
            if (ramenable == 2'b01) ram_cnt++;
            if (win == 1 && sb_q.size() > 0) begin
                check("decode_pcctl", 32'(pcControl), 32'(sb_q[0].pcctl));
                check("decode_quiet", {28'd0, dp_step, regenable, ramenable}, 32'd0);
            end
            if (dp_step) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_dp_step", 32'(dp_step), 32'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("exec_regen", 32'(regenable), 32'(mon_e.regen));
                    check("exec_ramen", 32'(ramenable), 32'(mon_e.ramen));
                    check("exec_pcctl", 32'(pcControl), 32'(mon_e.pcctl));
                    check("exec_cycles", 32'(win), 32'(mon_e.busy));
                    check("ram_cycles", 32'(ram_cnt), 32'(mon_e.ram_cycles));
                    check("retired_before", retired, 32'(retired_model));
                    check("illegal_before", 32'(illegal), 32'(illegal_model));
                    if (mon_e.chk_alu) begin
                        check("exec_alucode", 32'(alucode), 32'(mon_e.alucode));
                        check("exec_imm", 32'(imControl), 32'(mon_e.imm));
                        check("exec_wc", 32'(writecode), 32'(mon_e.wc));
                    end
                    if (mon_e.ramen == 2'b01) check("exec_wc_load", 32'(writecode), 32'(mon_e.wc));
                    if (mon_e.chk_ops) check("exec_ops", {22'd0, op1, op2}, {22'd0, mon_e.op1, mon_e.op2});
                    $display("txn %0d ins=%08h op=%0d cycles=%0d retired=%0d", txn, mon_e.ins,
                             mon_e.ins[31:27], win, retired);
                    txn++;
                    retired_model++;
                    if (mon_e.ill) illegal_model = 1'b1;
                end
                steps = steps + 32'd1;
            end
        end
    end

    initial begin
        int t;
        pc_base = 32'd5;
        repeat (3) @(negedge clock);
        check("reset_ctrl", {8'd0, alucode, op1, op2, imControl, regenable, ramenable, pcControl, writecode}, 32'd0);
        check("reset_misc", {18'd0, imem_req, imem_addr, dp_step, halted, illegal}, 32'd0);
        check("reset_retired", retired, 32'd0);
        reset = 1'b0;

        // ADD r3, r4 at pc=5 with immediate ack.
        @(negedge clock);
        check("add_fetch_req", 32'(imem_req), 32'd1);
        check("add_fetch_addr", 32'(imem_addr), 32'd5);
        fetch_one(mk(1, 0, 3, 4), 0);
        @(negedge clock);
        check("add_exec_step", 32'(dp_step), 32'd1);
        check("add_exec_fields", {16'd0, alucode, op1, op2, imControl},
              {16'd0, 5'd1, 5'd3, 5'd4, 1'b0});
        check("add_exec_regen", 32'(regenable), 32'd1);
        @(negedge clock);
        check("add_retired", retired, 32'd1);

        // LOAD: MEMWAIT x2 then EXECUTE, ramenable=01 throughout.
        fetch_one(mk(13, 0, 7, 2), 0);
        check("load_decode_wc", 32'(writecode), 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("load_ramen", 32'(ramenable), 32'b01);
            check("load_step", 32'(dp_step), 32'(i == 2));
        end

        // BRANCH cond 3.
        fetch_one(mk(15, 3, 1, 1), 0);
        check("branch_decode_pcctl", 32'(pcControl), 32'd3);
        @(negedge clock);
        check("branch_exec", {27'd0, pcControl, regenable, dp_step}, {27'd0, 3'd3, 1'b0, 1'b1});
        check("branch_ramen", 32'(ramenable), 32'd0);

        // Slow instruction memory.
        fetch_one(mk(2, 1, 9, 17), 4);

        // Randomized run.
        for (int n = 0; n < 80; n++) begin
            fetch_one(rand_instr(1'b1), int'($urandom_range(0, 3)));
        end
        t = 0;
        while (sb_q.size() != 0 && t < 50) begin
            @(negedge clock);
            t++;
        end
        check("random_drain", 32'(sb_q.size()), 32'd0);

        // Reset asserted in MEMWAIT clears everything at once.
        fetch_one(mk(13, 0, 5, 6), 0);
        @(negedge clock);
        check("pre_reset_ramen", 32'(ramenable), 32'b01);
        reset = 1'b1;
        #1;
        check("async_ctrl", {8'd0, alucode, op1, op2, imControl, regenable, ramenable, pcControl, writecode}, 32'd0);
        check("async_misc", {18'd0, imem_req, imem_addr, dp_step, halted, illegal}, 32'd0);
        check("async_retired", retired, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_fetch", 32'(imem_req), 32'd1);

        // Illegal opcode then HALT.
        fetch_one(mk(20, 5, 3, 3), 0);
        @(negedge clock);
        check("illegal_step", 32'(dp_step), 32'd1);
        @(negedge clock);
        check("illegal_flag", 32'(illegal), 32'd1);
        check("illegal_retired", retired, 32'd1);
        fetch_one(mk(31, 0, 0, 0), 0);
        @(negedge clock);
        check("halted", 32'(halted), 32'd1);
        imem_ack = 1'b1;
        for (int i = 0; i < 20; i++) begin
            imem_data = $urandom;
            @(negedge clock);
            check("halt_quiet", {29'd0, imem_req, dp_step, halted}, 32'b001);
            check("halt_retired", retired, 32'd1);
        end
        imem_ack = 1'b0;
        check("final_queue", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
